word_sum_enum: RTL and testbench

Inverse of the word digit-sum path: given a target sum, enumerates every N-digit word (2 bits per digit, digit 0 in bits [1:0]) whose unsigned digit sum equals the target.
- Matching words are emitted one at a time on a valid/ready stream.
- A final match count and a done pulse follow the last word.
- Used to generate candidate word sets for weight-constrained codebooks.

---
 rtl/word_sum_enum.sv | 139 +++++++++++++
 tb/tb_word_sum_enum.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_sum_enum.sv
// Enumerates every N-digit word (2-bit digits) whose digit sum equals a latched target, one word per handshake.
// Optional WORD_SUM_ENUM_DESCEND_EN: scan candidates from 4^N-1 down to 0 instead of ascending.
module word_sum_enum #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [9:0]     target_sum,
  output logic           busy,
  output logic [2*N-1:0] word_out,
  output logic           word_valid,
  input  logic           word_ready,
  output logic           done,
  output logic [2*N:0]   match_count
);

  localparam int W = 2 * N;
  localparam logic [9:0] MAX_SUM = 10'(3 * N);

`ifdef WORD_SUM_ENUM_DESCEND_EN
  localparam logic [W-1:0] CAND_FIRST = {W{1'b1}};
  localparam logic [W-1:0] CAND_LAST  = {W{1'b0}};
`else
  localparam logic [W-1:0] CAND_FIRST = {W{1'b0}};
  localparam logic [W-1:0] CAND_LAST  = {W{1'b1}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cand_q, cand_d;
  logic [9:0]   target_q, target_d;
  logic [W-1:0] word_q, word_d;
  logic         vld_q, vld_d;
  logic [W:0]   count_q, count_d;

  logic [9:0]   digit_sum;
  logic [W-1:0] cand_next;
  logic         is_last;
  logic         is_match;

  always_comb begin
    digit_sum = 10'd0;
    for (int i = 0; i < N; i++) begin
      digit_sum = digit_sum + 10'(cand_q[2*i +: 2]);
    end
  end

  always_comb begin
`ifdef WORD_SUM_ENUM_DESCEND_EN
    cand_next = cand_q - W'(1);
`else
    cand_next = cand_q + W'(1);
`endif
  end

  assign is_last  = (cand_q == CAND_LAST);
  assign is_match = (digit_sum == target_q);

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    target_d = target_q;
    word_d   = word_q;
    vld_d    = vld_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d = target_sum;
          count_d  = '0;
          cand_d   = CAND_FIRST;
          // Unreachable targets skip the scan entirely.
          state_d  = (target_sum > MAX_SUM) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (is_match) begin
          word_d  = cand_q;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end else if (is_last) begin
          state_d = S_DONE;
        end else begin
          cand_d = cand_next;
        end
      end
      S_HOLD: begin
        if (word_ready) begin
          vld_d   = 1'b0;
          count_d = count_q + (W+1)'(1);
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            cand_d  = cand_next;
            state_d = S_SCAN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      target_q <= '0;
      word_q   <= '0;
      vld_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      target_q <= target_d;
      word_q   <= word_d;
      vld_q    <= vld_d;
      count_q  <= count_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign word_out    = word_q;
  assign word_valid  = vld_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_word_sum_enum.sv
// Randomized bench for word_sum_enum (N=4) against a brute-force digit-sum reference.
module tb_word_sum_enum;
  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [9:0]   target_sum;
  logic         busy;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready;
  logic         done;
  logic [W:0]   match_count;

  always #5 clk = ~clk;

  word_sum_enum #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .target_sum(target_sum),
    .busy(busy),
    .word_out(word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .done(done),
    .match_count(match_count)
  );

  int checks = 0;
  int passes = 0;

  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int done_cnt, done_cyc, fall_cyc, stable_err, vld_seen, done_busy_err;
  bit timed_out;

  // Every word 0..4^N-1 whose digits add to tgt, in emission order.
  task automatic build_model(input int tgt);
    int s;
    exp_q.delete();
    for (int w = 0; w < (1 << W); w++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += (w >> (2 * k)) & 3;
      if (s == tgt) begin
`ifdef WORD_SUM_ENUM_DESCEND_EN
        exp_q.push_front(W'(w));
`else
        exp_q.push_back(W'(w));
`endif
      end
    end
  endtask

  // Index of first disagreement between got_q and exp_q, -1 when identical.
  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Starts a run and consumes words until busy drops; called just after a clock edge.
  task automatic do_run(input int tgt, input int rdy_pct, input int stall);
    int stall_left;
    bit prev_vld, prev_acc;
    logic [W-1:0] prev_word;
    got_q.delete();
    done_cnt = 0; done_cyc = -1; fall_cyc = -1; stable_err = 0;
    vld_seen = 0; done_busy_err = 0; timed_out = 1;
    stall_left = stall; prev_vld = 0; prev_acc = 0; prev_word = '0;
    start = 1'b1; target_sum = 10'(tgt); word_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      target_sum = 10'($urandom_range(0, 1023));
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (!busy) done_busy_err++;
      end
      if (!busy) begin
        fall_cyc = cyc;
        timed_out = 0;
        break;
      end
      if (word_valid) begin
        vld_seen++;
        if (prev_vld && !prev_acc && word_out !== prev_word) stable_err++;
      end
      if (word_valid && stall_left > 0) begin
        word_ready = 1'b0;
        start = 1'b1;
        stall_left--;
      end else begin
        word_ready = ($urandom_range(0, 99) < rdy_pct);
        start = ($urandom_range(0, 7) == 0);
      end
      prev_vld = word_valid;
      prev_word = word_out;
      prev_acc = word_valid && word_ready;
      if (prev_acc) got_q.push_back(word_out);
      @(posedge clk); #1;
    end
    start = 1'b0;
    word_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; word_ready = 1'b0; target_sum = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passes++;
    checks++; if (word_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", word_valid); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else passes++;
    checks++; if (word_out !== '0) $display("FAIL reset_word got=%h want=0", word_out); else passes++;
    checks++; if (match_count !== '0) $display("FAIL reset_count got=%0d want=0", match_count); else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_target_zero();
    int d;
    build_model(0);
    do_run(0, 100, 0);
    d = first_diff();
    checks++; if (timed_out) $display("FAIL t0_timeout got=busy want=idle"); else passes++;
    checks++; if (d >= 0) $display("FAIL t0_words idx=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size()); else passes++;
    checks++; if (match_count !== (W+1)'(1)) $display("FAIL t0_count got=%0d want=1", match_count); else passes++;
    checks++; if (done_cnt != 1) $display("FAIL t0_done_pulses got=%0d want=1", done_cnt); else passes++;
    checks++; if (fall_cyc != done_cyc + 1) $display("FAIL t0_busy_fall got=%0d want=%0d", fall_cyc, done_cyc + 1); else passes++;
    checks++; if (done_busy_err != 0) $display("FAIL t0_busy_in_done got=%0d want=0", done_busy_err); else passes++;
  endtask

  task automatic test_target_one();
    int d;
    build_model(1);
    do_run(1, 100, 0);
    d = first_diff();
    checks++; if (d >= 0) $display("FAIL t1_words idx=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size()); else passes++;
    checks++; if (match_count !== (W+1)'(4)) $display("FAIL t1_count got=%0d want=4", match_count); else passes++;
  endtask

  task automatic test_target_six();
    int d;
    build_model(6);
    do_run(6, 100, 0);
    d = first_diff();
    checks++; if (d >= 0) $display("FAIL t6_words idx=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size()); else passes++;
    checks++; if (match_count !== (W+1)'(44)) $display("FAIL t6_count got=%0d want=44", match_count); else passes++;
    checks++; if (done_cyc < 0 || done_cyc > 256 + 44 + 4) $display("FAIL t6_done_latency got=%0d want<=%0d", done_cyc, 256 + 44 + 4); else passes++;
  endtask

  task automatic test_out_of_range();
    int d;
    do_run(13, 100, 0);
    checks++; if (vld_seen != 0) $display("FAIL t13_valid got=%0d want=0", vld_seen); else passes++;
    checks++; if (done_cyc < 1 || done_cyc > 2) $display("FAIL t13_done_cycle got=%0d want=1..2", done_cyc); else passes++;
    checks++; if (match_count !== '0) $display("FAIL t13_count got=%0d want=0", match_count); else passes++;
    build_model(12);
    do_run(12, 100, 0);
    d = first_diff();
    checks++; if (d >= 0 || got_q.size() != 1) $display("FAIL t12_words idx=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size()); else passes++;
    checks++; if (match_count !== (W+1)'(1)) $display("FAIL t12_count got=%0d want=1", match_count); else passes++;
  endtask

  task automatic test_stall();
    int d;
    build_model(1);
    do_run(1, 100, 5);
    d = first_diff();
    checks++; if (stable_err != 0) $display("FAIL stall_stable got=%0d want=0", stable_err); else passes++;
    checks++; if (d >= 0) $display("FAIL stall_words idx=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size()); else passes++;
    checks++; if (match_count !== (W+1)'(4)) $display("FAIL stall_count got=%0d want=4", match_count); else passes++;
  endtask

  task automatic test_reset_mid_run();
    int d, cyc;
    got_q.delete();
    start = 1'b1; target_sum = 10'd6; word_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 0; cyc < 2000 && got_q.size() < 3; cyc++) begin
      word_ready = ($urandom_range(0, 99) < 70);
      if (word_valid && word_ready) got_q.push_back(word_out);
      @(posedge clk); #1;
    end
    checks++; if (got_q.size() < 3) $display("FAIL rst_mid_timeout got=%0d want=3", got_q.size()); else passes++;
    rst = 1'b1; word_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b want=0", busy); else passes++;
    checks++; if (word_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b want=0", word_valid); else passes++;
    checks++; if (word_out !== '0) $display("FAIL rst_mid_word got=%h want=0", word_out); else passes++;
    checks++; if (match_count !== '0) $display("FAIL rst_mid_count got=%0d want=0", match_count); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    build_model(2);
    do_run(2, 100, 0);
    d = first_diff();
    checks++; if (d >= 0) $display("FAIL rst_t2_words idx=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size()); else passes++;
    checks++; if (match_count !== (W+1)'(exp_q.size())) $display("FAIL rst_t2_count got=%0d want=%0d", match_count, exp_q.size()); else passes++;
  endtask

  task automatic test_random_targets();
    int d, tgt, pct;
    for (int it = 0; it < 6; it++) begin
      tgt = $urandom_range(0, 14);
      pct = $urandom_range(40, 100);
      build_model(tgt);
      do_run(tgt, pct, 0);
      d = first_diff();
      checks++; if (timed_out) $display("FAIL rnd_timeout tgt=%0d got=busy want=idle", tgt); else passes++;
      checks++; if (d >= 0) $display("FAIL rnd_words tgt=%0d idx=%0d got_n=%0d want_n=%0d", tgt, d, got_q.size(), exp_q.size()); else passes++;
      checks++; if (match_count !== (W+1)'(exp_q.size())) $display("FAIL rnd_count tgt=%0d got=%0d want=%0d", tgt, match_count, exp_q.size()); else passes++;
      checks++; if (done_cnt != 1) $display("FAIL rnd_done_pulses tgt=%0d got=%0d want=1", tgt, done_cnt); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_target_zero();
    test_target_one();
    test_target_six();
    test_out_of_range();
    test_stall();
    test_reset_mid_run();
    test_random_targets();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
